// File: rtl/otter_reg_file_sb.sv
// OTTER register file with a load scoreboard: per-register busy bits plus an
// in-order FIFO of outstanding load destinations, with write/return bypassing.
module otter_reg_file_sb #(
  parameter int LD_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  ADR1,
  input  logic [4:0]  ADR2,
  output logic [31:0] RS1,
  output logic [31:0] RS2,
  input  logic        EN,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic        LD_ISSUE,
  input  logic [4:0]  LD_RD,
  input  logic        LD_VALID,
  input  logic [31:0] LD_DATA,
  output logic        STALL,
  output logic [4:0]  LD_PEND,
  output logic        LD_ERR
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(LD_DEPTH);

  logic [31:0]   regs [32];
  logic [31:0]   busy;
  logic [4:0]    fifo [LD_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [4:0]    count;

  logic        pop;
  logic        full;
  logic        wr_en;
  logic        push;
  logic [4:0]  head_rd;
  logic [31:0] busy_eff;

  // Hazard checks see busy bits with this cycle's load return already retired.
  always_comb begin
    head_rd  = fifo[head];
    pop      = LD_VALID && (count != 5'd0);
    full     = (count == DEPTH_CNT);
    busy_eff = busy;
    if (pop) busy_eff[head_rd] = 1'b0;
    STALL = 1'b0;
    if ((ADR1 != 5'd0) && busy_eff[ADR1]) STALL = 1'b1;
    if ((ADR2 != 5'd0) && busy_eff[ADR2]) STALL = 1'b1;
    if (EN && busy_eff[WA]) STALL = 1'b1;
    if (LD_ISSUE && (LD_RD != 5'd0) && busy_eff[LD_RD]) STALL = 1'b1;
    if (LD_ISSUE && full && !pop) STALL = 1'b1;
    if (!RST_N) STALL = 1'b0;
    wr_en = EN && !STALL && (WA != 5'd0);
    push  = LD_ISSUE && !STALL;
  end

  function automatic logic [31:0] read_port(input logic [4:0] adr);
    logic [31:0] val;
    val = regs[adr];
    if (pop && (head_rd == adr)) val = LD_DATA;
    if (wr_en && (WA == adr)) val = WD;
    if (adr == 5'd0) val = 32'd0;
    return val;
  endfunction

  always_comb begin
    RS1 = 32'd0;
    RS2 = 32'd0;
    if (RST_N) begin
      RS1 = read_port(ADR1);
      RS2 = read_port(ADR2);
    end
  end

  // A return clears busy before a same-cycle issue may set it again.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      for (int i = 0; i < LD_DEPTH; i++) fifo[i] <= 5'd0;
      busy   <= 32'd0;
      head   <= '0;
      tail   <= '0;
      count  <= 5'd0;
      LD_ERR <= 1'b0;
    end else begin
      if (pop) begin
        if (head_rd != 5'd0) regs[head_rd] <= LD_DATA;
        busy[head_rd] <= 1'b0;
        head <= head + PW'(1);
      end
      if (wr_en) regs[WA] <= WD;
      if (push) begin
        fifo[tail] <= LD_RD;
        tail <= tail + PW'(1);
        if (LD_RD != 5'd0) busy[LD_RD] <= 1'b1;
      end
      count <= count + {4'd0, push} - {4'd0, pop};
      if (LD_VALID && (count == 5'd0)) LD_ERR <= 1'b1;
    end
  end

  assign LD_PEND = count;

endmodule

// File: tb/tb_otter_reg_file_sb.sv
// Scoreboard bench for otter_reg_file_sb: a queue-based reference model
// predicts every cycle's outputs, and a negedge monitor compares them.
module tb_otter_reg_file_sb;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  ADR1, ADR2, WA, LD_RD;
  logic [31:0] RS1, RS2, WD, LD_DATA;
  logic        EN, LD_ISSUE, LD_VALID;
  logic        STALL, LD_ERR;
  logic [4:0]  LD_PEND;

  otter_reg_file_sb #(.LD_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .ADR1(ADR1), .ADR2(ADR2), .RS1(RS1), .RS2(RS2),
    .EN(EN), .WA(WA), .WD(WD), .LD_ISSUE(LD_ISSUE), .LD_RD(LD_RD),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .STALL(STALL), .LD_PEND(LD_PEND),
    .LD_ERR(LD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic [4:0]  adr1, adr2, wa, ld_rd;
    logic        en, ld_issue, ld_valid;
    logic [31:0] wd, ld_data;
  } stim_t;

  typedef struct {
    logic        stall;
    logic [31:0] rs1, rs2;
    logic [4:0]  ld_pend;
    logic        ld_err;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_regs [32];
  logic [4:0]  pending [$];
  logic        model_err = 1'b0;
  stim_t       cur;
  logic        cur_stall;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.adr1 = 5'd0; s.adr2 = 5'd0; s.wa = 5'd0; s.ld_rd = 5'd0;
    s.en = 1'b0; s.ld_issue = 1'b0; s.ld_valid = 1'b0;
    s.wd = 32'd0; s.ld_data = 32'd0;
    return s;
  endfunction

  // A register is busy while some load still outstanding after this cycle's return targets it.
  function automatic logic still_busy(input logic [4:0] rd, input logic popping);
    if (rd == 5'd0) return 1'b0;
    for (int i = (popping ? 1 : 0); i < pending.size(); i++)
      if (pending[i] == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_stall(input stim_t s);
    logic popping;
    popping = s.ld_valid && (pending.size() > 0);
    if (!s.rst_n) return 1'b0;
    if (still_busy(s.adr1, popping) || still_busy(s.adr2, popping)) return 1'b1;
    if (s.en && still_busy(s.wa, popping)) return 1'b1;
    if (s.ld_issue && still_busy(s.ld_rd, popping)) return 1'b1;
    if (s.ld_issue && (pending.size() == DEPTH) && !popping) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input stim_t s, input logic [4:0] adr, input logic stl);
    if (!s.rst_n || adr == 5'd0) return 32'd0;
    if (s.en && !stl && s.wa == adr) return s.wd;
    if (s.ld_valid && pending.size() > 0 && pending[0] == adr) return s.ld_data;
    return model_regs[adr];
  endfunction

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    if (!s.rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      pending.delete();
      model_err = 1'b0;
    end
    cur = s;
    cur_stall = model_stall(s);
    RST_N = s.rst_n; ADR1 = s.adr1; ADR2 = s.adr2; EN = s.en; WA = s.wa; WD = s.wd;
    LD_ISSUE = s.ld_issue; LD_RD = s.ld_rd; LD_VALID = s.ld_valid; LD_DATA = s.ld_data;
    e.stall   = cur_stall;
    e.rs1     = model_read(s, s.adr1, cur_stall);
    e.rs2     = model_read(s, s.adr2, cur_stall);
    e.ld_pend = 5'(pending.size());
    e.ld_err  = model_err;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic finish_cycle();
    logic [4:0] h;
    @(posedge CLK);
    if (cur.rst_n) begin
      if (cur.ld_valid) begin
        if (pending.size() > 0) begin
          h = pending.pop_front();
          if (h != 5'd0) model_regs[h] = cur.ld_data;
        end else model_err = 1'b1;
      end
      if (cur.en && !cur_stall && cur.wa != 5'd0) model_regs[cur.wa] = cur.wd;
      if (cur.ld_issue && !cur_stall) pending.push_back(cur.ld_rd);
    end
    #1;
  endtask

  task automatic run_cycle(input stim_t s);
    apply_stimulus(s);
    finish_cycle();
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_value("sb_stall", {31'd0, STALL}, {31'd0, e.stall});
      check_value("sb_rs1", RS1, e.rs1);
      check_value("sb_rs2", RS2, e.rs2);
      check_value("sb_ld_pend", {27'd0, LD_PEND}, {27'd0, e.ld_pend});
      check_value("sb_ld_err", {31'd0, LD_ERR}, {31'd0, e.ld_err});
    end
  end

  initial begin
    stim_t s;
    RST_N = 1'b0; ADR1 = 5'd0; ADR2 = 5'd0; EN = 1'b0; WA = 5'd0; WD = 32'd0;
    LD_ISSUE = 1'b0; LD_RD = 5'd0; LD_VALID = 1'b0; LD_DATA = 32'd0;
    @(posedge CLK); #1;

    // Reset with active-looking inputs: outputs must stay quiet.
    s = idle(); s.rst_n = 1'b0; s.en = 1'b1; s.wa = 5'd5; s.wd = 32'hAAAA5555; s.adr1 = 5'd5;
    apply_stimulus(s);
    check_value("rst_rs1", RS1, 32'd0);
    check_value("rst_stall", {31'd0, STALL}, 32'd0);
    finish_cycle();

    // Write with same-cycle bypass, then from storage.
    s = idle(); s.en = 1'b1; s.wa = 5'd5; s.wd = 32'hDEADBEEF; s.adr1 = 5'd5;
    apply_stimulus(s); check_value("wr_bypass", RS1, 32'hDEADBEEF); finish_cycle();
    s = idle(); s.adr1 = 5'd5;
    apply_stimulus(s); check_value("wr_storage", RS1, 32'hDEADBEEF); finish_cycle();

    // x0 ignores writes and loads, but a load to x0 still occupies the FIFO.
    s = idle(); s.en = 1'b1; s.wa = 5'd0; s.wd = 32'hFFFFFFFF;
    apply_stimulus(s); check_value("x0_write", RS1, 32'd0); finish_cycle();
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'd0;
    apply_stimulus(s); check_value("x0_issue_stall", {31'd0, STALL}, 32'd0); finish_cycle();
    s = idle();
    apply_stimulus(s); check_value("x0_pend_one", {27'd0, LD_PEND}, 32'd1); finish_cycle();
    s = idle(); s.ld_valid = 1'b1; s.ld_data = 32'h55AA55AA;
    run_cycle(s);
    s = idle();
    apply_stimulus(s);
    check_value("x0_pend_zero", {27'd0, LD_PEND}, 32'd0);
    check_value("x0_rs1", RS1, 32'd0);
    finish_cycle();

    // RAW on a pending load, released by the return itself.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'd7; run_cycle(s);
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.adr1 = 5'd7;
      apply_stimulus(s); check_value("raw_stall", {31'd0, STALL}, 32'd1); finish_cycle();
    end
    s = idle(); s.adr1 = 5'd7; s.ld_valid = 1'b1; s.ld_data = 32'h12345678;
    apply_stimulus(s);
    check_value("raw_release", {31'd0, STALL}, 32'd0);
    check_value("raw_bypass", RS1, 32'h12345678);
    finish_cycle();

    // Full FIFO: stall on issue unless a return frees a slot the same cycle.
    for (int r = 1; r <= 4; r++) begin
      s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'(r); run_cycle(s);
    end
    s = idle();
    apply_stimulus(s); check_value("full_pend", {27'd0, LD_PEND}, 32'd4); finish_cycle();
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'd5;
    apply_stimulus(s); check_value("full_stall", {31'd0, STALL}, 32'd1); finish_cycle();
    s.ld_valid = 1'b1; s.ld_data = 32'h00000111;
    apply_stimulus(s); check_value("full_pop_issue", {31'd0, STALL}, 32'd0); finish_cycle();
    s = idle();
    apply_stimulus(s); check_value("full_pend_kept", {27'd0, LD_PEND}, 32'd4); finish_cycle();
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.ld_valid = 1'b1; s.ld_data = $urandom; run_cycle(s);
    end
    s = idle();
    apply_stimulus(s); check_value("drain_pend", {27'd0, LD_PEND}, 32'd0); finish_cycle();

    // Reset discards outstanding loads; a later return sets the sticky error.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'd10; run_cycle(s);
    s.ld_rd = 5'd11; run_cycle(s);
    s = idle();
    apply_stimulus(s); check_value("two_pend", {27'd0, LD_PEND}, 32'd2); finish_cycle();
    s = idle(); s.rst_n = 1'b0; s.adr1 = 5'd10;
    apply_stimulus(s);
    check_value("rst_pend", {27'd0, LD_PEND}, 32'd0);
    check_value("rst_mid_stall", {31'd0, STALL}, 32'd0);
    finish_cycle();
    s = idle(); s.adr1 = 5'd10;
    apply_stimulus(s); check_value("post_rst_busy", {31'd0, STALL}, 32'd0); finish_cycle();
    s = idle(); s.ld_valid = 1'b1; s.ld_data = 32'hBAD0BAD0; run_cycle(s);
    s = idle();
    apply_stimulus(s); check_value("err_set", {31'd0, LD_ERR}, 32'd1); finish_cycle();
    run_cycle(s); run_cycle(s);
    apply_stimulus(s); check_value("err_sticky", {31'd0, LD_ERR}, 32'd1); finish_cycle();
    s = idle(); s.rst_n = 1'b0;
    apply_stimulus(s); check_value("err_cleared", {31'd0, LD_ERR}, 32'd0); finish_cycle();

    // WAW: a write to a pending load's destination waits for the return.
    s = idle(); s.ld_issue = 1'b1; s.ld_rd = 5'd9; run_cycle(s);
    s = idle(); s.en = 1'b1; s.wa = 5'd9; s.wd = 32'hCAFEF00D;
    apply_stimulus(s); check_value("waw_stall", {31'd0, STALL}, 32'd1); finish_cycle();
    s = idle(); s.ld_valid = 1'b1; s.ld_data = 32'h11111111; s.adr1 = 5'd9;
    apply_stimulus(s); check_value("waw_return", RS1, 32'h11111111); finish_cycle();
    s = idle(); s.en = 1'b1; s.wa = 5'd9; s.wd = 32'hCAFEF00D; s.adr1 = 5'd9;
    apply_stimulus(s);
    check_value("waw_proceed", {31'd0, STALL}, 32'd0);
    check_value("waw_bypass", RS1, 32'hCAFEF00D);
    finish_cycle();
    s = idle(); s.adr1 = 5'd9;
    apply_stimulus(s); check_value("waw_final", RS1, 32'hCAFEF00D); finish_cycle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 99) != 0);
      s.adr1     = 5'($urandom_range(0, 7));
      s.adr2     = 5'($urandom_range(0, 7));
      s.en       = 1'($urandom_range(0, 1));
      s.wa       = 5'($urandom_range(0, 7));
      s.wd       = $urandom;
      s.ld_issue = ($urandom_range(0, 2) == 0);
      s.ld_rd    = 5'($urandom_range(0, 7));
      s.ld_valid = ($urandom_range(0, 2) == 0);
      s.ld_data  = $urandom;
      if (s.ld_valid && pending.size() > 0 && s.en && s.wa != 5'd0 && s.wa == pending[0])
        s.en = 1'b0;
      run_cycle(s);
    end

    s = idle();
    apply_stimulus(s);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
